// File: rtl/sec_demux_pkg.sv
// Shared definitions for the two-domain demultiplexing queue: domain labels
// and the occupancy-count width helper.
package sec_demux_pkg;

  localparam logic DOMAIN_L0 = 1'b0;
  localparam logic DOMAIN_L1 = 1'b1;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sec_queue.sv
// Single-domain FIFO with masked output and optional freed-entry scrubbing.
// Optional feature macro: SEC_DEMUX_SCRUB_EN.
module sec_queue
  import sec_demux_pkg::*;
#(
  parameter int p_nbits = 32,
  parameter int p_depth = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enq_val,
  output logic                          enq_rdy,
  input  logic [p_nbits-1:0]            enq_msg,
  output logic                          deq_val,
  input  logic                          deq_rdy,
  output logic [p_nbits-1:0]            deq_msg,
  output logic [cnt_width(p_depth)-1:0] cnt
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = cnt_width(p_depth);

  logic [p_nbits-1:0] mem [p_depth];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [CW-1:0]      cnt_q;
  logic               full;
  logic               empty;
  logic               enq;
  logic               deq;

  always_comb begin
    full    = (cnt_q == CW'(p_depth));
    empty   = (cnt_q == '0);
    enq_rdy = ~full;
    deq_val = ~empty;
    enq     = enq_val & ~full;
    deq     = deq_val & deq_rdy;
    deq_msg = deq_val ? mem[rptr] : '0;
    cnt     = cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < p_depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
`ifdef SEC_DEMUX_SCRUB_EN
      // Head and tail differ whenever both fire, so scrub and write never collide.
      if (deq) mem[rptr] <= '0;
`endif
      if (enq) begin
        mem[wptr] <= enq_msg;
        wptr      <= wptr + 1'b1;
      end
      if (deq) rptr <= rptr + 1'b1;
      if (enq && !deq)      cnt_q <= cnt_q + 1'b1;
      else if (deq && !enq) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/sec_demux2_queue.sv
// Steers a sel-tagged valid/ready stream into per-domain queues L0 and L1.
// Optional feature macro: SEC_DEMUX_SCRUB_EN (scrub freed queue entries).
module sec_demux2_queue
  import sec_demux_pkg::*;
#(
  parameter int p_nbits = 32,
  parameter int p_depth = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_val,
  output logic                          in_rdy,
  input  logic [p_nbits-1:0]            in_msg,
  input  logic                          sel,
  output logic                          out0_val,
  input  logic                          out0_rdy,
  output logic [p_nbits-1:0]            out0_msg,
  output logic                          out1_val,
  input  logic                          out1_rdy,
  output logic [p_nbits-1:0]            out1_msg,
  output logic [cnt_width(p_depth)-1:0] cnt0,
  output logic [cnt_width(p_depth)-1:0] cnt1
);

  logic rdy0;
  logic rdy1;
  logic enq0;
  logic enq1;

  always_comb begin
    in_rdy = (sel == DOMAIN_L1) ? rdy1 : rdy0;
    enq0   = in_val & in_rdy & (sel == DOMAIN_L0);
    enq1   = in_val & in_rdy & (sel == DOMAIN_L1);
  end

  sec_queue #(.p_nbits(p_nbits), .p_depth(p_depth)) u_q0 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq0),
    .enq_rdy (rdy0),
    .enq_msg (in_msg),
    .deq_val (out0_val),
    .deq_rdy (out0_rdy),
    .deq_msg (out0_msg),
    .cnt     (cnt0)
  );

  sec_queue #(.p_nbits(p_nbits), .p_depth(p_depth)) u_q1 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq1),
    .enq_rdy (rdy1),
    .enq_msg (in_msg),
    .deq_val (out1_val),
    .deq_rdy (out1_rdy),
    .deq_msg (out1_msg),
    .cnt     (cnt1)
  );

endmodule

// File: doc/sec_demux2_queue.md
Name: sec_demux2_queue

Overview:
- Two-domain demultiplexer with one FIFO per destination domain; the counterpart to the two-input domain mux.
- Accepts one valid/ready message stream tagged with a 1-bit `sel` and steers each message into the queue for domain L0 or domain L1.
- Each queue drains on its own valid/ready output port.
- Sits between a shared producer and per-domain consumers. The two domains never share a storage entry, so no data from one domain is observable on the other domain's port.

Parameters:
- p_nbits, 32: message payload width.
- p_depth, 2: entries per domain queue; power of two, >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_val  input  1  producer message valid.
- in_rdy  output  1  block can accept a message for the domain selected by `sel`.
- in_msg  input  p_nbits  producer payload.
- sel  input  1  destination domain (0 = L0, 1 = L1); public label, sampled with in_val.
- out0_val  output  1  L0 queue non-empty.
- out0_rdy  input  1  L0 consumer ready.
- out0_msg  output  p_nbits  L0 head payload.
- out1_val  output  1  L1 queue non-empty.
- out1_rdy  input  1  L1 consumer ready.
- out1_msg  output  p_nbits  L1 head payload.
- cnt0  output  log2(p_depth)+1  L0 occupancy.
- cnt1  output  log2(p_depth)+1  L1 occupancy.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous-release assumed upstream):
  - all pointers and counts = 0; all storage entries = 0.
  - out0_val = out1_val = 0; out*_msg = 0; cnt0 = cnt1 = 0.
- in_rdy:
  - combinational: ~full[sel], where full[d] = (cnt_d == p_depth).
  - Depends only on `sel` and the selected queue's count, never on the other queue.
- Enqueue:
  - fires when in_val & in_rdy; writes in_msg into queue[sel] at its write pointer.
  - Write pointer increments modulo p_depth (wrap-around via natural log2(p_depth)-bit overflow).
- Dequeue:
  - queue d fires when outd_val & outd_rdy; its read pointer increments modulo p_depth.
- Latency: a message enqueued at edge N appears on outd_msg with outd_val = 1 after edge N (no combinational bypass).
- outd_val = (cnt_d != 0).
- outd_msg:
  - equals the head entry when outd_val = 1.
  - forced to 0 when outd_val = 0; empty ports never expose stale data.
- Count update per queue:
  - +1 on enqueue only; -1 on dequeue only; unchanged on both or neither.
- Boundary conditions:
  - Full queue: in_rdy = 0 for that sel even if the same queue dequeues in the same cycle (no pass-through when full).
  - Empty queue: no dequeue possible; no underflow.
  - Simultaneous enqueue into L0 and dequeue from L1 (or any cross-domain mix) is fully independent.
- sel when in_val = 0: ignored; no state change.
- Ordering: FIFO within a domain; no ordering guarantee across domains.
- Reset mid-operation: all queued messages are discarded immediately; outputs return to their reset values asynchronously.

Optional Feature:
- Macro: SEC_DEMUX_SCRUB_EN.
- Defined: on dequeue, the freed storage entry is written to 0 in the same edge (scrub), so no residual payload remains in storage. An enqueue into that same entry in the same cycle cannot occur, because the write targets the tail entry.
- Undefined: freed entries keep their old contents until overwritten. Port-level masking (outd_msg = 0 when empty) still applies.

Decomposition:
- Package sec_demux_pkg holds:
  - DOMAIN_L0 = 1'b0 and DOMAIN_L1 = 1'b1.
  - The count-width function clog2(p_depth)+1.
- Sub-module sec_queue (param p_nbits, p_depth) owns storage, pointers, count, full/empty, output masking and optional scrub.
- Top level instantiates sec_queue twice and adds the steering logic:
  - in_rdy mux.
  - enq gating: enq0 = in_val & in_rdy & ~sel; enq1 = in_val & in_rdy & sel.

Test Plan:
- Reset, then 3 idle cycles → out0_val = out1_val = 0, out0_msg = out1_msg = 0, cnt0 = cnt1 = 0, in_rdy = 1.
- Enqueue 0xA1 (sel = 0), then 0xB2 (sel = 1), consumers not ready → cnt0 = 1, cnt1 = 1; out0_msg = 0xA1, out1_msg = 0xB2, each one cycle after its enqueue.
- Fill L0 with 0x10, 0x11 (p_depth = 2), then present sel = 0 → in_rdy = 0. Present sel = 1 with 0x20 → accepted, cnt1 = 1, L0 unaffected.
- With L0 full, assert out0_rdy and in_val with sel = 0 and 0x12 in the same cycle → 0x10 dequeued, 0x12 not accepted, cnt0 = 1. Next cycle accepted, cnt0 = 2; drain order is 0x11, 0x12.
- Stream 5 messages 0x1..0x5 through L0 with out0_rdy = 1 → pointers wrap; output order is 0x1..0x5; cnt0 never exceeds 1 after steady state.
- Assert reset low mid-stream with cnt0 = 2 → outputs zero immediately (before next clk edge). With SEC_DEMUX_SCRUB_EN, dequeue 0x10 → storage entry reads 0 via hierarchical check.
